// File: rtl/alu_operand_sequencer_if.sv
// Board-side bundle for the ALU operand sequencer: switches, buttons and ALU result in,
// operand/opcode/state/result-valid/LED out.
interface alu_operand_sequencer_if #(
  parameter int BUS_LEN = 8,
  parameter int OP_LEN  = 6
);
  logic [BUS_LEN-1:0] i_sw;
  logic               i_btn_next;
  logic               i_btn_back;
  logic [BUS_LEN-1:0] i_result;
  logic [BUS_LEN-1:0] o_ope1;
  logic [BUS_LEN-1:0] o_ope2;
  logic [OP_LEN-1:0]  o_opcode;
  logic [1:0]         o_state;
  logic               o_valid;
  logic [BUS_LEN-1:0] o_led;

  modport master (
    output i_sw, i_btn_next, i_btn_back, i_result,
    input  o_ope1, o_ope2, o_opcode, o_state, o_valid, o_led
  );

  modport slave (
    input  i_sw, i_btn_next, i_btn_back, i_result,
    output o_ope1, o_ope2, o_opcode, o_state, o_valid, o_led
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-stepped operand/opcode loader and result latch for the ALU lab board.
// Optional button debouncing is enabled by defining ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer #(
  parameter int BUS_LEN         = 8,
  parameter int OP_LEN          = 6,
  parameter int ALU_LAT         = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_operand_sequencer_if.slave bus
);
  localparam logic [1:0] S_A   = 2'd0;
  localparam logic [1:0] S_B   = 2'd1;
  localparam logic [1:0] S_OP  = 2'd2;
  localparam logic [1:0] S_RES = 2'd3;

  localparam int CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_MAX = CNT_W'(ALU_LAT);

  // Index 0 = NEXT, index 1 = BACK
  logic [1:0] btnRaw;
  logic [1:0] btnPulse;

  assign btnRaw = {bus.i_btn_back, bus.i_btn_next};

  for (genvar gi = 0; gi < 2; gi++) begin : genBtn
    logic [1:0] syncReg;
    logic       levelReg;
    logic       cleanLevel;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) syncReg <= 2'b00;
      else       syncReg <= {syncReg[0], btnRaw[gi]};
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    logic [DB_W-1:0] dbCntReg;
    logic            dbLevelReg;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dbCntReg   <= '0;
        dbLevelReg <= 1'b0;
      end else if (syncReg[1] != dbLevelReg) begin
        if (dbCntReg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          dbLevelReg <= syncReg[1];
          dbCntReg   <= '0;
        end else begin
          dbCntReg <= dbCntReg + 1'b1;
        end
      end else begin
        dbCntReg <= '0;
      end
    end

    assign cleanLevel = dbLevelReg;
`else
    assign cleanLevel = syncReg[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) levelReg <= 1'b0;
      else       levelReg <= cleanLevel;
    end

    assign btnPulse[gi] = cleanLevel & ~levelReg;
  end

  logic nextEv;
  logic backEv;
  assign nextEv = btnPulse[0] & ~btnPulse[1];
  assign backEv = btnPulse[1] & ~btnPulse[0];

  logic [1:0]         stateReg;
  logic [BUS_LEN-1:0] ope1Reg;
  logic [BUS_LEN-1:0] ope2Reg;
  logic [OP_LEN-1:0]  opcodeReg;
  logic [BUS_LEN-1:0] resultReg;
  logic               validReg;
  logic [CNT_W-1:0]   latCntReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= S_A;
      ope1Reg   <= '0;
      ope2Reg   <= '0;
      opcodeReg <= '0;
      resultReg <= '0;
      validReg  <= 1'b0;
      latCntReg <= '0;
    end else if (nextEv) begin
      case (stateReg)
        S_A: begin
          ope1Reg  <= bus.i_sw;
          stateReg <= S_B;
        end
        S_B: begin
          ope2Reg  <= bus.i_sw;
          stateReg <= S_OP;
        end
        S_OP: begin
          opcodeReg <= bus.i_sw[OP_LEN-1:0];
          latCntReg <= '0;
          stateReg  <= S_RES;
        end
        default: begin
          validReg <= 1'b0;
          stateReg <= S_A;
        end
      endcase
    end else if (backEv) begin
      case (stateReg)
        S_B:     stateReg <= S_A;
        S_OP:    stateReg <= S_B;
        S_RES: begin
          validReg <= 1'b0;
          stateReg <= S_OP;
        end
        default: stateReg <= S_A;
      endcase
    end else if (stateReg == S_RES) begin
      // Sample the ALU exactly once per pass, on the cycle the counter sits at ALU_LAT
      if (latCntReg != LAT_MAX) begin
        latCntReg <= latCntReg + 1'b1;
      end else if (!validReg) begin
        resultReg <= bus.i_result;
        validReg  <= 1'b1;
      end
    end
  end

  assign bus.o_ope1   = ope1Reg;
  assign bus.o_ope2   = ope2Reg;
  assign bus.o_opcode = opcodeReg;
  assign bus.o_state  = stateReg;
  assign bus.o_valid  = validReg;
  assign bus.o_led    = validReg ? resultReg : bus.i_sw;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: expected output events are queued as buttons
// are pressed and compared whenever o_state or o_valid changes.
module tb_alu_operand_sequencer;
  localparam int ALU_LAT = 1;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int DEB = 4;
`else
  localparam int DEB = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_operand_sequencer_if #(.BUS_LEN(8), .OP_LEN(6)) bus ();

  alu_operand_sequencer #(
    .BUS_LEN(8), .OP_LEN(6), .ALU_LAT(ALU_LAT), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [1:0] state;
    logic [7:0] ope1;
    logic [7:0] ope2;
    logic [5:0] opcode;
    logic       valid;
    logic [7:0] led;
    bit         lat;
  } expT;

  expT expQ[$];
  int checkCount = 0;
  int passCount = 0;
  int cyc = 0;
  int pressCyc = 0;
  int resCyc = 0;
  logic [1:0] prevState = 2'd0;
  logic       prevValid = 1'b0;

  logic [1:0] mState = 2'd0;
  logic [7:0] m1 = 8'h00;
  logic [7:0] m2 = 8'h00;
  logic [5:0] mOp = 6'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: every change of state/valid is one output transaction
  always @(negedge clk) begin
    expT e;
    if (reset) begin
      prevState = bus.o_state;
      prevValid = bus.o_valid;
    end else if (bus.o_state != prevState || bus.o_valid != prevValid) begin
      if (bus.o_state == 2'd3 && prevState != 2'd3) resCyc = cyc;
      if (bus.o_valid && !prevValid) checkVal("validLat", cyc - resCyc, ALU_LAT + 1);
      $display("txn cyc=%0d state=%0d ope1=%02h ope2=%02h opcode=%02h valid=%0d led=%02h",
               cyc, bus.o_state, bus.o_ope1, bus.o_ope2, bus.o_opcode, bus.o_valid, bus.o_led);
      if (expQ.size() == 0) begin
        checkVal("unexpState", bus.o_state, prevState);
        checkVal("unexpValid", bus.o_valid, prevValid);
      end else begin
        e = expQ.pop_front();
        checkVal("state", bus.o_state, e.state);
        checkVal("ope1", bus.o_ope1, e.ope1);
        checkVal("ope2", bus.o_ope2, e.ope2);
        checkVal("opcode", bus.o_opcode, e.opcode);
        checkVal("valid", bus.o_valid, e.valid);
        checkVal("led", bus.o_led, e.led);
        if (e.lat) checkVal("stepLat", cyc - pressCyc, 3 + DEB);
      end
      prevState = bus.o_state;
      prevValid = bus.o_valid;
    end
  end

  task automatic pushExp(input bit lat, input logic [7:0] led, input logic valid);
    expQ.push_back('{mState, m1, m2, mOp, valid, led, lat});
  endtask

  task automatic modelNext(input logic [7:0] sw, input logic [7:0] res, input bit lat);
    case (mState)
      2'd0: begin m1 = sw; mState = 2'd1; pushExp(lat, sw, 1'b0); end
      2'd1: begin m2 = sw; mState = 2'd2; pushExp(lat, sw, 1'b0); end
      2'd2: begin
        mOp = sw[5:0]; mState = 2'd3;
        pushExp(lat, sw, 1'b0);
        pushExp(1'b0, res, 1'b1);
      end
      default: begin mState = 2'd0; pushExp(lat, sw, 1'b0); end
    endcase
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      checkVal("timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  task automatic driveBtn(input bit nx, input bit bk, input logic [7:0] sw, input int hold);
    @(negedge clk);
    bus.i_sw = sw;
    bus.i_btn_next = nx;
    bus.i_btn_back = bk;
    pressCyc = cyc;
    repeat (hold) @(negedge clk);
    bus.i_btn_next = 1'b0;
    bus.i_btn_back = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    drain();
  endtask

  task automatic doNext(input logic [7:0] sw, input logic [7:0] res);
    bus.i_result = res;
    modelNext(sw, res, 1'b1);
    driveBtn(1'b1, 1'b0, sw, 8);
  endtask

  task automatic doBack(input logic [7:0] sw);
    if (mState != 2'd0) begin
      mState = mState - 2'd1;
      pushExp(1'b1, sw, 1'b0);
    end
    driveBtn(1'b0, 1'b1, sw, 8);
  endtask

  initial begin
    bus.i_sw = 8'h5A;
    bus.i_btn_next = 1'b0;
    bus.i_btn_back = 1'b0;
    bus.i_result = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("rstState", bus.o_state, 0);
    checkVal("rstOpe1", bus.o_ope1, 0);
    checkVal("rstOpe2", bus.o_ope2, 0);
    checkVal("rstOpcode", bus.o_opcode, 0);
    checkVal("rstValid", bus.o_valid, 0);
    checkVal("rstLed", bus.o_led, 8'h5A);

    // Full sequence
    doNext(8'h3C, 8'h00);
    doNext(8'h05, 8'h00);
    doNext(8'h2A, 8'h41);
    bus.i_result = 8'h99;
    repeat (5) @(negedge clk);
    checkVal("ledHold", bus.o_led, 8'h41);
    doNext(8'h77, 8'h00);
    checkVal("ledEcho", bus.o_led, 8'h77);

    // BACK stepping, including BACK in S_A and out of S_RES
    doNext(8'h11, 8'h00);
    doNext(8'h22, 8'h00);
    doBack(8'h22);
    doBack(8'h22);
    doBack(8'h22);
    checkVal("backIdleState", bus.o_state, 0);
    checkVal("backIdleOpe1", bus.o_ope1, 8'h11);
    doNext(8'h11, 8'h00);
    doNext(8'h22, 8'h00);
    doNext(8'h03, 8'hC3);
    doBack(8'h03);
    doNext(8'h03, 8'h5E);
    doNext(8'h44, 8'h00);
    doNext(8'h44, 8'h00);

    // Simultaneous NEXT and BACK in S_B
    driveBtn(1'b1, 1'b1, 8'h99, 8);
    checkVal("bothState", bus.o_state, 1);
    checkVal("bothOpe2", bus.o_ope2, 8'h22);

    // Long hold from S_A advances once
    doBack(8'h44);
    modelNext(8'h66, 8'h00, 1'b1);
    driveBtn(1'b1, 1'b0, 8'h66, 50);

    // Async reset while showing a valid result, NEXT held across release
    doNext(8'h01, 8'h00);
    doNext(8'h02, 8'hA5);
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.i_sw = 8'hB7;
    bus.i_btn_next = 1'b1;
    #1;
    checkVal("arstState", bus.o_state, 0);
    checkVal("arstOpe1", bus.o_ope1, 0);
    checkVal("arstOpe2", bus.o_ope2, 0);
    checkVal("arstOpcode", bus.o_opcode, 0);
    checkVal("arstValid", bus.o_valid, 0);
    checkVal("arstLed", bus.o_led, 8'hB7);
    mState = 2'd0; m1 = 8'h00; m2 = 8'h00; mOp = 6'h00;
    modelNext(8'hB7, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    bus.i_btn_next = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    drain();
    checkVal("heldState", bus.o_state, 1);

`ifdef ALU_SEQ_DEBOUNCE_EN
    // Short glitch is swallowed, bouncy press gives one step
    driveBtn(1'b1, 1'b0, 8'h12, 3);
    checkVal("glitchState", bus.o_state, 1);
    modelNext(8'h34, 8'h00, 1'b0);
    @(negedge clk);
    bus.i_sw = 8'h34;
    bus.i_btn_next = 1'b1;
    @(negedge clk) bus.i_btn_next = 1'b0;
    @(negedge clk) bus.i_btn_next = 1'b1;
    @(negedge clk) bus.i_btn_next = 1'b0;
    @(negedge clk) bus.i_btn_next = 1'b1;
    repeat (10) @(negedge clk);
    bus.i_btn_next = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    drain();
    checkVal("bounceState", bus.o_state, 2);
`endif

    repeat (10) @(negedge clk);
    checkVal("queueEmpty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
